fmadd_mantissa_addsub_stage: RTL and testbench

- Pipeline stage directly downstream of the FMADD exponent-matching stage.
- Captures the aligned mantissas, the guard/round/sticky bits, sign, exponent and effective-operation flags.
- Performs the effective add or magnitude subtract with GRS carried through the arithmetic.
- Presents a carry-extended raw sum to the normalisation/rounding stage behind a two-register valid/ready pipeline.

---
 rtl/fmadd_mantissa_addsub_stage.sv | 175 +++++++++++++++++
 tb/tb_fmadd_mantissa_addsub_stage.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/fmadd_mantissa_addsub_stage.sv
// FMADD mantissa add/subtract stage: registers the aligned operands, then forms the
// carry-extended sum or magnitude difference with guard/round/sticky carried through.
module fmadd_mantissa_addsub_stage #(
   parameter int man = 22,
   parameter int exp = 7
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_flush,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [2*man+3:0]     in_mantissa_a,
   input  logic [2*man+3:0]     in_mantissa_b,
   input  logic [exp+1:0]       in_exp,
   input  logic                 in_sign,
   input  logic                 in_guard,
   input  logic                 in_round,
   input  logic                 in_sticky,
   input  logic                 in_eff_sub,
   input  logic                 in_a_gt_b,
   input  logic                 in_a_eq_b,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*man+4:0]     out_mantissa,
   output logic                 out_guard,
   output logic                 out_round,
   output logic                 out_sticky,
   output logic [exp+1:0]       out_exp,
   output logic                 out_sign,
   output logic                 out_zero,
   output logic                 out_eff_sub
);
   localparam int MW = 2*man+4;
   localparam int W  = 2*man+7;
   localparam int EW = exp+2;

   logic          s1_valid_q, s1_valid_d;
   logic [MW-1:0] s1_ma_q, s1_ma_d, s1_mb_q, s1_mb_d;
   logic [EW-1:0] s1_exp_q, s1_exp_d;
   logic [2:0]    s1_grs_q, s1_grs_d;
   logic          s1_sign_q, s1_sign_d, s1_eff_sub_q, s1_eff_sub_d;
   logic          s1_a_gt_b_q, s1_a_gt_b_d, s1_a_eq_b_q, s1_a_eq_b_d;

   logic          s2_valid_q, s2_valid_d;
   logic [MW:0]   s2_mant_q, s2_mant_d;
   logic [2:0]    s2_grs_q, s2_grs_d;
   logic [EW-1:0] s2_exp_q, s2_exp_d;
   logic          s2_sign_q, s2_sign_d, s2_zero_q, s2_zero_d, s2_eff_sub_q, s2_eff_sub_d;

   logic          s2_adv, s1_adv, in_fire;
   logic [MW-1:0] large_op, small_op;
   logic [W:0]    ext_l, ext_s, raw;

   // The smaller-magnitude operand is the one that was shifted and owns the GRS bits.
   genvar gi;
   generate
      for (gi = 0; gi < MW; gi++) begin : g_swap
         assign large_op[gi] = s1_a_gt_b_q ? s1_ma_q[gi] : s1_mb_q[gi];
         assign small_op[gi] = s1_a_gt_b_q ? s1_mb_q[gi] : s1_ma_q[gi];
      end
   endgenerate

   assign s2_adv   = ~s2_valid_q | out_ready;
   assign s1_adv   = s1_valid_q & s2_adv;
   assign in_ready = (~s1_valid_q | s2_adv) & ~in_flush;
   assign in_fire  = in_valid & in_ready;

   always_comb begin
      ext_l = {1'b0, large_op, 3'b000};
      ext_s = {1'b0, small_op, s1_grs_q};
      raw   = s1_eff_sub_q ? (ext_l - ext_s) : (ext_l + ext_s);

      s1_valid_d   = s1_valid_q;
      s1_ma_d      = s1_ma_q;
      s1_mb_d      = s1_mb_q;
      s1_exp_d     = s1_exp_q;
      s1_grs_d     = s1_grs_q;
      s1_sign_d    = s1_sign_q;
      s1_eff_sub_d = s1_eff_sub_q;
      s1_a_gt_b_d  = s1_a_gt_b_q;
      s1_a_eq_b_d  = s1_a_eq_b_q;
      s2_valid_d   = s2_valid_q;
      s2_mant_d    = s2_mant_q;
      s2_grs_d     = s2_grs_q;
      s2_exp_d     = s2_exp_q;
      s2_sign_d    = s2_sign_q;
      s2_zero_d    = s2_zero_q;
      s2_eff_sub_d = s2_eff_sub_q;

      if (in_ready)
         s1_valid_d = in_valid;
      if (in_fire) begin
         s1_ma_d      = in_mantissa_a;
         s1_mb_d      = in_mantissa_b;
         s1_exp_d     = in_exp;
         s1_grs_d     = {in_guard, in_round, in_sticky};
         s1_sign_d    = in_sign;
         s1_eff_sub_d = in_eff_sub;
         s1_a_gt_b_d  = in_a_gt_b;
         s1_a_eq_b_d  = in_a_eq_b;
      end

      if (s2_adv)
         s2_valid_d = s1_valid_q;
      if (s1_adv && !in_flush) begin
         s2_exp_d     = s1_exp_q;
         s2_eff_sub_d = s1_eff_sub_q;
         if (s1_a_eq_b_q) begin
            s2_mant_d = '0;
            s2_grs_d  = 3'b000;
            s2_sign_d = 1'b0;
            s2_zero_d = 1'b1;
         end else begin
            s2_mant_d = raw[W:3];
            s2_grs_d  = raw[2:0];
            s2_sign_d = s1_sign_q;
            s2_zero_d = (raw == '0);
         end
      end

      // Flush wins over any transfer in the same cycle; data registers are left alone.
      if (in_flush) begin
         s1_valid_d = 1'b0;
         s2_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_q   <= 1'b0;
         s1_ma_q      <= '0;
         s1_mb_q      <= '0;
         s1_exp_q     <= '0;
         s1_grs_q     <= '0;
         s1_sign_q    <= 1'b0;
         s1_eff_sub_q <= 1'b0;
         s1_a_gt_b_q  <= 1'b0;
         s1_a_eq_b_q  <= 1'b0;
         s2_valid_q   <= 1'b0;
         s2_mant_q    <= '0;
         s2_grs_q     <= '0;
         s2_exp_q     <= '0;
         s2_sign_q    <= 1'b0;
         s2_zero_q    <= 1'b0;
         s2_eff_sub_q <= 1'b0;
      end else begin
         s1_valid_q   <= s1_valid_d;
         s1_ma_q      <= s1_ma_d;
         s1_mb_q      <= s1_mb_d;
         s1_exp_q     <= s1_exp_d;
         s1_grs_q     <= s1_grs_d;
         s1_sign_q    <= s1_sign_d;
         s1_eff_sub_q <= s1_eff_sub_d;
         s1_a_gt_b_q  <= s1_a_gt_b_d;
         s1_a_eq_b_q  <= s1_a_eq_b_d;
         s2_valid_q   <= s2_valid_d;
         s2_mant_q    <= s2_mant_d;
         s2_grs_q     <= s2_grs_d;
         s2_exp_q     <= s2_exp_d;
         s2_sign_q    <= s2_sign_d;
         s2_zero_q    <= s2_zero_d;
         s2_eff_sub_q <= s2_eff_sub_d;
      end
   end

   assign out_valid    = s2_valid_q;
   assign out_mantissa = s2_mant_q;
   assign out_guard    = s2_grs_q[2];
   assign out_round    = s2_grs_q[1];
   assign out_sticky   = s2_grs_q[0];
   assign out_exp      = s2_exp_q;
   assign out_sign     = s2_sign_q;
   assign out_zero     = s2_zero_q;
   assign out_eff_sub  = s2_eff_sub_q;
endmodule

// File: tb/tb_fmadd_mantissa_addsub_stage.sv
// Directed bench for the mantissa add/subtract stage: arithmetic vectors, latency,
// back-pressure ordering, flush and reset drops.
module tb_fmadd_mantissa_addsub_stage;
   logic        clk = 1'b0;
   logic        rst, in_flush, in_valid, in_ready;
   logic [47:0] in_mantissa_a, in_mantissa_b;
   logic [8:0]  in_exp;
   logic        in_sign, in_guard, in_round, in_sticky, in_eff_sub, in_a_gt_b, in_a_eq_b;
   logic        out_valid, out_ready;
   logic [48:0] out_mantissa;
   logic        out_guard, out_round, out_sticky, out_sign, out_zero, out_eff_sub;
   logic [8:0]  out_exp;

   int vectors = 0;
   int miscompares = 0;

   fmadd_mantissa_addsub_stage #(.man(22), .exp(7)) dut (
      .clk(clk), .rst(rst), .in_flush(in_flush), .in_valid(in_valid), .in_ready(in_ready),
      .in_mantissa_a(in_mantissa_a), .in_mantissa_b(in_mantissa_b), .in_exp(in_exp),
      .in_sign(in_sign), .in_guard(in_guard), .in_round(in_round), .in_sticky(in_sticky),
      .in_eff_sub(in_eff_sub), .in_a_gt_b(in_a_gt_b), .in_a_eq_b(in_a_eq_b),
      .out_valid(out_valid), .out_ready(out_ready), .out_mantissa(out_mantissa),
      .out_guard(out_guard), .out_round(out_round), .out_sticky(out_sticky),
      .out_exp(out_exp), .out_sign(out_sign), .out_zero(out_zero), .out_eff_sub(out_eff_sub)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      vectors++;
      assert (obs === expv)
      else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   task automatic drive(input logic [47:0] a, input logic [47:0] b, input logic [8:0] e,
                        input logic sg, input logic [2:0] grs, input logic sub,
                        input logic gt, input logic eq);
      in_mantissa_a = a;
      in_mantissa_b = b;
      in_exp        = e;
      in_sign       = sg;
      {in_guard, in_round, in_sticky} = grs;
      in_eff_sub    = sub;
      in_a_gt_b     = gt;
      in_a_eq_b     = eq;
      in_valid      = 1'b1;
   endtask

   // One isolated transaction with out_ready=1: presented, captured, result two edges on.
   task automatic run_vec(input string tag, input logic [47:0] a, input logic [47:0] b,
                          input logic [8:0] e, input logic sg, input logic [2:0] grs,
                          input logic sub, input logic gt, input logic eq,
                          input logic [48:0] em, input logic [2:0] eg, input logic ez,
                          input logic es);
      drive(a, b, e, sg, grs, sub, gt, eq);
      #1;
      check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
      tick();
      in_valid = 1'b0;
      check({tag, "_latency"}, 64'(out_valid), 64'd0);
      tick();
      check({tag, "_valid"}, 64'(out_valid), 64'd1);
      check({tag, "_mant"}, 64'(out_mantissa), 64'(em));
      check({tag, "_grs"}, 64'({out_guard, out_round, out_sticky}), 64'(eg));
      check({tag, "_zero"}, 64'(out_zero), 64'(ez));
      check({tag, "_sign"}, 64'(out_sign), 64'(es));
      check({tag, "_exp"}, 64'(out_exp), 64'(e));
      check({tag, "_effsub"}, 64'(out_eff_sub), 64'(sub));
      $display("txn %s: mant=%h grs=%b zero=%b sign=%b", tag, out_mantissa,
               {out_guard, out_round, out_sticky}, out_zero, out_sign);
   endtask

   // Load both pipeline registers with tagged entries while downstream is stalled.
   task automatic fill_two(input string tag);
      out_ready = 1'b0;
      drive(48'h1000, 48'h1, 9'd20, 1'b0, 3'b000, 1'b0, 1'b1, 1'b0);
      tick();
      drive(48'h2000, 48'h1, 9'd21, 1'b0, 3'b000, 1'b0, 1'b1, 1'b0);
      tick();
      in_valid = 1'b0;
      #1;
      check({tag, "_full_valid"}, 64'(out_valid), 64'd1);
      check({tag, "_full_ready"}, 64'(in_ready), 64'd0);
   endtask

   initial begin
      rst = 1'b1; in_flush = 1'b0; out_ready = 1'b1;
      drive('0, '0, '0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0);
      in_valid = 1'b0;
      tick();
      rst = 1'b0;
      check("reset_out_valid", 64'(out_valid), 64'd0);
      check("reset_in_ready", 64'(in_ready), 64'd1);
      check("reset_mant", 64'(out_mantissa), 64'd0);
      check("reset_flags", 64'({out_guard, out_round, out_sticky, out_sign, out_zero, out_eff_sub}), 64'd0);
      check("reset_exp", 64'(out_exp), 64'd0);

      run_vec("add", 48'h4000_0000_0000, 48'h2000_0000_0000, 9'd100, 1'b0, 3'b101, 1'b0, 1'b1, 1'b0,
              49'h0_6000_0000_0000, 3'b101, 1'b0, 1'b0);
      run_vec("sub_borrow", 48'h4000_0000_0000, 48'h0000_0000_0001, 9'd101, 1'b1, 3'b100, 1'b1, 1'b1, 1'b0,
              49'h0_3FFF_FFFF_FFFE, 3'b100, 1'b0, 1'b1);
      run_vec("sub_swap", 48'h0000_0000_0001, 48'h4000_0000_0000, 9'd102, 1'b0, 3'b100, 1'b1, 1'b0, 1'b0,
              49'h0_3FFF_FFFF_FFFE, 3'b100, 1'b0, 1'b0);
      run_vec("cancel", 48'h5555_0000_0000, 48'h5555_0000_0000, 9'd103, 1'b1, 3'b000, 1'b1, 1'b1, 1'b1,
              49'h0, 3'b000, 1'b1, 1'b0);
      run_vec("carry", 48'hFFFF_FFFF_FFFF, 48'hFFFF_FFFF_FFFF, 9'd104, 1'b0, 3'b000, 1'b0, 1'b1, 1'b0,
              49'h1_FFFF_FFFF_FFFE, 3'b000, 1'b0, 1'b0);
      run_vec("zero_add", 48'h0, 48'h0, 9'd105, 1'b1, 3'b000, 1'b0, 1'b1, 1'b0,
              49'h0, 3'b000, 1'b1, 1'b1);
      run_vec("grs_carry", 48'h0000_0000_0010, 48'h0000_0000_0001, 9'd106, 1'b0, 3'b111, 1'b0, 1'b1, 1'b0,
              49'h0_0000_0000_0011, 3'b111, 1'b0, 1'b0);
      tick();

      // Back-pressure: four tagged entries, downstream stalled.
      out_ready = 1'b0;
      drive(48'h1000, 48'h1, 9'd1, 1'b0, 3'b000, 1'b0, 1'b1, 1'b0);
      #1; check("bp_accept0", 64'(in_ready), 64'd1);
      tick();
      drive(48'h2000, 48'h1, 9'd2, 1'b0, 3'b000, 1'b0, 1'b1, 1'b0);
      #1; check("bp_accept1", 64'(in_ready), 64'd1);
      tick();
      drive(48'h3000, 48'h1, 9'd3, 1'b0, 3'b000, 1'b0, 1'b1, 1'b0);
      #1; check("bp_full_ready", 64'(in_ready), 64'd0);
      check("bp_head_exp", 64'(out_exp), 64'd1);
      tick();
      check("bp_stall_valid", 64'(out_valid), 64'd1);
      check("bp_stall_exp", 64'(out_exp), 64'd1);
      check("bp_stall_mant", 64'(out_mantissa), 64'h1001);
      check("bp_stall_ready", 64'(in_ready), 64'd0);
      out_ready = 1'b1;
      #1; check("bp_release_ready", 64'(in_ready), 64'd1);
      tick();
      check("bp_out1_valid", 64'(out_valid), 64'd1);
      check("bp_out1_exp", 64'(out_exp), 64'd2);
      drive(48'h4000, 48'h1, 9'd4, 1'b0, 3'b000, 1'b0, 1'b1, 1'b0);
      tick();
      in_valid = 1'b0;
      check("bp_out2_exp", 64'(out_exp), 64'd3);
      check("bp_out2_mant", 64'(out_mantissa), 64'h3001);
      tick();
      check("bp_out3_valid", 64'(out_valid), 64'd1);
      check("bp_out3_exp", 64'(out_exp), 64'd4);
      tick();
      check("bp_drained", 64'(out_valid), 64'd0);
      $display("txn backpressure: 4 entries drained in order");

      // Flush with both registers full, competing input and output transfers.
      fill_two("flush");
      drive(48'h9000, 48'h1, 9'd30, 1'b0, 3'b000, 1'b0, 1'b1, 1'b0);
      in_flush = 1'b1;
      out_ready = 1'b1;
      #1; check("flush_in_ready", 64'(in_ready), 64'd0);
      tick();
      in_flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      #1;
      check("flush_out_valid", 64'(out_valid), 64'd0);
      check("flush_in_ready_after", 64'(in_ready), 64'd1);
      check("flush_data_kept", 64'(out_exp), 64'd20);
      out_ready = 1'b1;
      tick();
      check("flush_no_pulse1", 64'(out_valid), 64'd0);
      tick();
      check("flush_no_pulse2", 64'(out_valid), 64'd0);
      $display("txn flush: held entries dropped");

      // Synchronous reset with both registers full.
      fill_two("rst");
      rst = 1'b1;
      out_ready = 1'b1;
      tick();
      rst = 1'b0;
      #1;
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_in_ready", 64'(in_ready), 64'd1);
      check("rst_mant", 64'(out_mantissa), 64'd0);
      check("rst_exp", 64'(out_exp), 64'd0);
      tick();
      check("rst_no_pulse1", 64'(out_valid), 64'd0);
      tick();
      check("rst_no_pulse2", 64'(out_valid), 64'd0);
      $display("txn reset: held entries dropped");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
